// File: rtl/argmax_classifier.sv
// Argmax over NUM_CLASSES signed scores, scanned one per clock from a snapshot.
// Reports winning index, its score, margin over the runner-up and confidence.
module argmax_classifier #(
    parameter int NUM_CLASSES = 10,
    parameter int DATA_W = 16,
    parameter logic [DATA_W-1:0] MARGIN_MIN = 16'd256
) (
    input  logic                       Clk,
    input  logic                       Reset_n,
    input  logic                       Start,
    input  logic [DATA_W-1:0]          Probability [NUM_CLASSES-1:0],
    output logic                       Busy,
    output logic                       Done,
    output logic                       Valid,
    output logic [$clog2(NUM_CLASSES)-1:0] Digit,
    output logic [DATA_W-1:0]          Max_Value,
    output logic [DATA_W-1:0]          Margin,
    output logic                       Confident,
    output logic [NUM_CLASSES-1:0]     Onehot
);
    localparam int IW = $clog2(NUM_CLASSES);
    localparam logic [IW-1:0] LAST = IW'(NUM_CLASSES - 1);
    localparam logic signed [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_e;

    state_e state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [IW-1:0] best_idx_q, best_idx_d;
    logic signed [DATA_W-1:0] best_q, best_d;
    logic signed [DATA_W-1:0] second_q, second_d;
    logic [DATA_W-1:0] snap_q [NUM_CLASSES-1:0];
    logic [DATA_W-1:0] snap_d [NUM_CLASSES-1:0];

    logic busy_q, busy_d;
    logic done_q, done_d;
    logic valid_q, valid_d;
    logic [IW-1:0] digit_q, digit_d;
    logic [DATA_W-1:0] max_q, max_d;
    logic [DATA_W-1:0] margin_q, margin_d;
    logic conf_q, conf_d;
    logic [NUM_CLASSES-1:0] onehot_q, onehot_d;

    logic accept;
    logic signed [DATA_W-1:0] cur;

    assign accept = Start && (state_q != SCAN);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            best_idx_q <= '0;
            best_q     <= MOST_NEG;
            second_q   <= MOST_NEG;
            snap_q     <= '{default: '0};
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            valid_q    <= 1'b0;
            digit_q    <= '0;
            max_q      <= '0;
            margin_q   <= '0;
            conf_q     <= 1'b0;
            onehot_q   <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            best_idx_q <= best_idx_d;
            best_q     <= best_d;
            second_q   <= second_d;
            snap_q     <= snap_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            valid_q    <= valid_d;
            digit_q    <= digit_d;
            max_q      <= max_d;
            margin_q   <= margin_d;
            conf_q     <= conf_d;
            onehot_q   <= onehot_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (Start) state_d = SCAN;
            SCAN:    if (idx_q == LAST) state_d = DONE;
            DONE:    state_d = Start ? SCAN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        snap_d     = snap_q;
        idx_d      = idx_q;
        best_d     = best_q;
        second_d   = second_q;
        best_idx_d = best_idx_q;
        cur        = snap_q[idx_q];
        if (accept) begin
            for (int i = 0; i < NUM_CLASSES; i++) snap_d[i] = Probability[i];
            idx_d      = '0;
            best_d     = MOST_NEG;
            second_d   = MOST_NEG;
            best_idx_d = '0;
        end else if (state_q == SCAN) begin
            // Strict compares: an equal later score only becomes runner-up
            if (cur > best_q) begin
                second_d   = best_q;
                best_d     = cur;
                best_idx_d = idx_q;
            end else if (cur > second_q) begin
                second_d = cur;
            end
            if (idx_q != LAST) idx_d = idx_q + 1'b1;
        end
    end

    always_comb begin
        busy_d   = (state_q == SCAN);
        done_d   = (state_q == DONE);
        valid_d  = valid_q;
        digit_d  = digit_q;
        max_d    = max_q;
        margin_d = margin_q;
        conf_d   = conf_q;
        onehot_d = onehot_q;
        if (state_q == DONE) begin
            valid_d  = 1'b1;
            digit_d  = best_idx_q;
            max_d    = best_q;
            // best >= second, so the modular difference is the true margin
            margin_d = best_q - second_q;
            conf_d   = margin_d >= MARGIN_MIN;
            onehot_d = NUM_CLASSES'(1) << best_idx_q;
        end
    end

    assign Busy      = busy_q;
    assign Done      = done_q;
    assign Valid     = valid_q;
    assign Digit     = digit_q;
    assign Max_Value = max_q;
    assign Margin    = margin_q;
    assign Confident = conf_q;
    assign Onehot    = onehot_q;
endmodule
